asi_reg_arb: RTL



---
 rtl/asi_reg_arb.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/asi_reg_arb.sv
// asi_reg_arb: round-robin arbiter between the register write and read
// request channels, sequencing one access at a time onto a shared req/ack
// register port with wait-state timeout and word-address decode check.
module asi_reg_arb #(
   parameter int REG_AW  = 20,
   parameter int REG_DW  = 32,
   parameter int L       = $clog2(REG_DW/8),
   parameter int REG_NUM = 1024,
   parameter int TIMEOUT = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_AW-L-1:0]   w_addr,
   input  logic [REG_DW-1:0]     w_data,
   input  logic [REG_DW/8-1:0]   w_strb,
   input  logic                  w_valid,
   output logic                  w_ready,
   output logic                  w_err,
   input  logic [REG_AW-L-1:0]   r_addr,
   input  logic                  r_valid,
   output logic                  r_ready,
   output logic [REG_DW-1:0]     r_rdata,
   output logic                  r_err,
   output logic                  reg_req,
   output logic                  reg_we,
   output logic [REG_AW-L-1:0]   reg_addr,
   output logic [REG_DW-1:0]     reg_wdata,
   output logic [REG_DW/8-1:0]   reg_wstrb,
   input  logic                  reg_ack,
   input  logic [REG_DW-1:0]     reg_rdata
);

   localparam int AW = REG_AW - L;
   localparam int SW = REG_DW / 8;
   // a zero TIMEOUT still needs a legal (unused) counter width
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

   state_t            state_q, state_d;
   logic              last_wr_q, last_wr_d;   // 0 = read granted last
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              reg_req_q, reg_req_d;
   logic              reg_we_q, reg_we_d;
   logic [AW-1:0]     reg_addr_q, reg_addr_d;
   logic [REG_DW-1:0] reg_wdata_q, reg_wdata_d;
   logic [SW-1:0]     reg_wstrb_q, reg_wstrb_d;
   logic              w_ready_q, w_ready_d;
   logic              w_err_q, w_err_d;
   logic              r_ready_q, r_ready_d;
   logic              r_err_q, r_err_d;
   logic [REG_DW-1:0] r_rdata_q, r_rdata_d;

   logic              gnt_wr, gnt_rd, dec_err, timeout_hit;
   logic [AW-1:0]     g_addr;
   logic              cpl_en, cpl_we, cpl_err;
   logic [REG_DW-1:0] cpl_rdata;

   // next-state: arbitration, access sequencing and completion reporting
   always_comb begin
      state_d     = state_q;
      last_wr_d   = last_wr_q;
      cnt_d       = cnt_q;
      reg_req_d   = reg_req_q;
      reg_we_d    = reg_we_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_wstrb_d = reg_wstrb_q;
      w_ready_d   = 1'b0;
      w_err_d     = w_err_q;
      r_ready_d   = 1'b0;
      r_err_d     = r_err_q;
      r_rdata_d   = r_rdata_q;
      cpl_en      = 1'b0;
      cpl_we      = reg_we_q;
      cpl_err     = 1'b0;
      cpl_rdata   = '0;

      // write wins unless a read is also pending and write went last
      gnt_wr      = w_valid && (!r_valid || !last_wr_q);
      gnt_rd      = r_valid && !gnt_wr;
      g_addr      = gnt_wr ? w_addr : r_addr;
      dec_err     = 32'(g_addr) >= REG_NUM;
      timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

      case (state_q)
         IDLE: begin
            if (gnt_wr || gnt_rd) begin
               last_wr_d   = gnt_wr;
               reg_we_d    = gnt_wr;
               reg_addr_d  = g_addr;
               reg_wdata_d = gnt_wr ? w_data : '0;
               reg_wstrb_d = gnt_wr ? w_strb : '0;
               cnt_d       = '0;
               if (dec_err) begin
                  // rejected without touching the register port
                  state_d = RESP;
                  cpl_en  = 1'b1;
                  cpl_we  = gnt_wr;
                  cpl_err = 1'b1;
               end else begin
                  reg_req_d = 1'b1;
                  state_d   = gnt_wr ? WR : RD;
               end
            end
         end
         WR, RD: begin
            if (reg_ack) begin
               // ack beats a simultaneous timeout
               reg_req_d = 1'b0;
               state_d   = RESP;
               cpl_en    = 1'b1;
               cpl_rdata = reg_rdata;
            end else if (timeout_hit) begin
               reg_req_d = 1'b0;
               state_d   = RESP;
               cpl_en    = 1'b1;
               cpl_err   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;   // RESP: one pulse, never re-samples valid
      endcase

      if (cpl_en) begin
         if (cpl_we) begin
            w_ready_d = 1'b1;
            w_err_d   = cpl_err;
         end else begin
            r_ready_d = 1'b1;
            r_err_d   = cpl_err;
            r_rdata_d = cpl_rdata;
         end
      end
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_wr_q   <= 1'b0;
         cnt_q       <= '0;
         reg_req_q   <= 1'b0;
         reg_we_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_wstrb_q <= '0;
         w_ready_q   <= 1'b0;
         w_err_q     <= 1'b0;
         r_ready_q   <= 1'b0;
         r_err_q     <= 1'b0;
         r_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         last_wr_q   <= last_wr_d;
         cnt_q       <= cnt_d;
         reg_req_q   <= reg_req_d;
         reg_we_q    <= reg_we_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_wstrb_q <= reg_wstrb_d;
         w_ready_q   <= w_ready_d;
         w_err_q     <= w_err_d;
         r_ready_q   <= r_ready_d;
         r_err_q     <= r_err_d;
         r_rdata_q   <= r_rdata_d;
      end
   end

   assign w_ready   = w_ready_q;
   assign w_err     = w_err_q;
   assign r_ready   = r_ready_q;
   assign r_err     = r_err_q;
   assign r_rdata   = r_rdata_q;
   assign reg_req   = reg_req_q;
   assign reg_we    = reg_we_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_wstrb = reg_wstrb_q;

endmodule
